// File: rtl/led_display_row_driver_if.sv
// Shared row types and the valid/ready row handshake into the HUB75 row driver.
package led_display_row_driver_pkg;

    localparam int unsigned GL_NUM_COL_PIXELS = 64;

    typedef struct packed {
        logic [GL_NUM_COL_PIXELS-1:0] red;
        logic [GL_NUM_COL_PIXELS-1:0] green;
        logic [GL_NUM_COL_PIXELS-1:0] blue;
    } rgb_half_t;

    typedef struct packed {
        rgb_half_t top;
        rgb_half_t bot;
    } rgb_row_t;

endpackage

interface led_display_row_driver_if;
    import led_display_row_driver_pkg::*;

    rgb_row_t row_in;
    logic     row_valid_in;
    logic     row_ready_out;

    modport master (output row_in, output row_valid_in, input row_ready_out);
    modport slave  (input row_in, input row_valid_in, output row_ready_out);

endinterface

// File: rtl/led_display_row_driver.sv
// HUB75 row driver: captures one rgb_row_t per handshake, shifts it out MSB
// pixel first, then blanks, latches and displays it on the next row address.
module led_display_row_driver
    import led_display_row_driver_pkg::*;
#(
    parameter int unsigned SYS_CLK_FREQ   = 100_000_000,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned CLK_DIV        = 4,
    parameter int unsigned BLANK_CYCLES   = 2,
    parameter int unsigned LATCH_CYCLES   = 2,
    parameter int unsigned DISPLAY_CYCLES = 256
) (
    input  logic                     clk_in,
    input  logic                     n_reset_in,
    led_display_row_driver_if.slave  row_if,
    output logic [5:0]               hub_rgb_out,
    output logic                     hub_clk_out,
    output logic                     hub_lat_out,
    output logic                     hub_oe_n_out,
    output logic [ADDR_W-1:0]        hub_addr_out
);

    localparam int unsigned PIX_W   = (GL_NUM_COL_PIXELS > 1) ? $clog2(GL_NUM_COL_PIXELS) : 1;
    localparam int unsigned CNT_MAX = CLK_DIV + BLANK_CYCLES + LATCH_CYCLES + DISPLAY_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    if (SYS_CLK_FREQ == 0 || CLK_DIV < 2 || (CLK_DIV % 2) != 0 ||
        BLANK_CYCLES == 0 || LATCH_CYCLES == 0 || DISPLAY_CYCLES == 0) begin : g_param_check
        $error("led_display_row_driver: illegal parameter set");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_DISPLAY
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [ADDR_W-1:0] row_cnt_q, row_cnt_d;
    rgb_row_t          row_q, row_d;
    logic              shown_q, shown_d;
    logic              arm_q;

    logic              ready_q, ready_d;
    logic [5:0]        rgb_d;
    logic              clk_d, lat_d, oe_n_d;
    logic [ADDR_W-1:0] addr_d;

    logic              take;

    assign take                 = row_if.row_valid_in && ready_q;
    assign row_if.row_ready_out = ready_q;

    // State register plus sequencing counters, capture register and "row shown" flag.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pix_q     <= '0;
            row_cnt_q <= '0;
            row_q     <= '0;
            shown_q   <= 1'b0;
            arm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pix_q     <= pix_d;
            row_cnt_q <= row_cnt_d;
            row_q     <= row_d;
            shown_q   <= shown_d;
            arm_q     <= 1'b1;
        end
    end

    // Next-state logic: cnt counts the pixel phase in SHIFT and the dwell time elsewhere.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pix_d     = pix_q;
        row_cnt_d = row_cnt_q;
        row_d     = row_q;
        shown_d   = shown_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    pix_d   = PIX_W'(GL_NUM_COL_PIXELS - 1);
                    row_d   = row_if.row_in;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (pix_q == '0) begin
                        state_d = ST_BLANK;
                    end else begin
                        pix_d = pix_q - 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = ST_LATCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LATCH: begin
                if (cnt_q == CNT_W'(LATCH_CYCLES - 1)) begin
                    state_d = ST_DISPLAY;
                    cnt_d   = '0;
                    shown_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DISPLAY: begin
                if (cnt_q == CNT_W'(DISPLAY_CYCLES - 1)) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    row_cnt_d = row_cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next-state values so the registered pins line up with the state.
    always_comb begin
        ready_d = arm_q && (state_d == ST_IDLE);
        rgb_d   = hub_rgb_out;
        if (state_d == ST_SHIFT && cnt_d == '0) begin
            rgb_d = {row_d.top.red[pix_d], row_d.top.green[pix_d], row_d.top.blue[pix_d],
                     row_d.bot.red[pix_d], row_d.bot.green[pix_d], row_d.bot.blue[pix_d]};
        end
        clk_d  = (state_d == ST_SHIFT) && (cnt_d >= CNT_W'(CLK_DIV / 2));
        lat_d  = (state_d == ST_LATCH);
        oe_n_d = !((state_d == ST_DISPLAY) || (state_d == ST_SHIFT && shown_q));
        addr_d = hub_addr_out;
        if (state_d == ST_BLANK && state_q != ST_BLANK) begin
            addr_d = row_cnt_q;
        end
    end

    // Registered panel pins and ready.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            ready_q      <= 1'b0;
            hub_rgb_out  <= '0;
            hub_clk_out  <= 1'b0;
            hub_lat_out  <= 1'b0;
            hub_oe_n_out <= 1'b1;
            hub_addr_out <= '0;
        end else begin
            ready_q      <= ready_d;
            hub_rgb_out  <= rgb_d;
            hub_clk_out  <= clk_d;
            hub_lat_out  <= lat_d;
            hub_oe_n_out <= oe_n_d;
            hub_addr_out <= addr_d;
        end
    end

endmodule

// File: tb/tb_led_display_row_driver.sv
// Directed self-checking bench for led_display_row_driver (64 px, default timing).
module tb_led_display_row_driver;
    import led_display_row_driver_pkg::*;

    logic       clk_in = 1'b0;
    logic       n_reset_in;
    logic [5:0] hub_rgb_out;
    logic       hub_clk_out;
    logic       hub_lat_out;
    logic       hub_oe_n_out;
    logic [3:0] hub_addr_out;

    int n_tests = 0;
    int n_fail  = 0;

    int         nrise, lat_cnt, oe_post, oe_shift, ready_cyc, inv_viol;
    logic [3:0] addr_lat;
    logic [5:0] rgb_cap [64];

    always #5 clk_in = ~clk_in;

    led_display_row_driver_if u_if ();

    led_display_row_driver #(
        .SYS_CLK_FREQ   (100_000_000),
        .ADDR_W         (4),
        .CLK_DIV        (4),
        .BLANK_CYCLES   (2),
        .LATCH_CYCLES   (2),
        .DISPLAY_CYCLES (256)
    ) dut (
        .clk_in       (clk_in),
        .n_reset_in   (n_reset_in),
        .row_if       (u_if.slave),
        .hub_rgb_out  (hub_rgb_out),
        .hub_clk_out  (hub_clk_out),
        .hub_lat_out  (hub_lat_out),
        .hub_oe_n_out (hub_oe_n_out),
        .hub_addr_out (hub_addr_out)
    );

    function automatic logic [5:0] pix_of(input rgb_row_t r, input int unsigned i);
        return {r.top.red[i], r.top.green[i], r.top.blue[i],
                r.bot.red[i], r.bot.green[i], r.bot.blue[i]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rgb"},   64'(hub_rgb_out), 64'd0);
        chk({tag, "_clk"},   64'(hub_clk_out), 64'd0);
        chk({tag, "_lat"},   64'(hub_lat_out), 64'd0);
        chk({tag, "_oe_n"},  64'(hub_oe_n_out), 64'd1);
        chk({tag, "_addr"},  64'(hub_addr_out), 64'd0);
        chk({tag, "_ready"}, 64'(u_if.row_ready_out), 64'd0);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (u_if.row_ready_out !== 1'b1 && n < 2000) begin
            @(negedge clk_in);
            n++;
        end
        chk({tag, "_ready_wait"}, 64'(n < 2000), 64'd1);
    endtask

    // Hands over one row and observes the pins until ready returns (cyc 0 = just after handshake edge).
    task automatic run_row(input string tag, input rgb_row_t r, input bit toggle);
        logic       prev_clk, prev_oe_n;
        logic [3:0] prev_addr;
        bit         seen_lat;
        u_if.row_in       = r;
        u_if.row_valid_in = 1'b1;
        wait_ready(tag);
        @(posedge clk_in);
        #1;
        u_if.row_valid_in = 1'b0;
        nrise = 0; lat_cnt = 0; oe_post = 0; oe_shift = 0; ready_cyc = -1; inv_viol = 0;
        addr_lat = 'x; seen_lat = 1'b0;
        prev_clk = 1'b0; prev_oe_n = hub_oe_n_out; prev_addr = hub_addr_out;
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (u_if.row_ready_out === 1'b1) begin
                ready_cyc = cyc;
                break;
            end
            if (hub_clk_out && !prev_clk) begin
                if (nrise < 64) rgb_cap[nrise] = hub_rgb_out;
                nrise++;
            end
            if (hub_lat_out) begin
                if (!seen_lat) addr_lat = hub_addr_out;
                seen_lat = 1'b1;
                lat_cnt++;
                if (!hub_oe_n_out || hub_clk_out) inv_viol++;
            end
            if (!hub_oe_n_out) begin
                if (seen_lat) oe_post++;
                else oe_shift++;
                if (!prev_oe_n && hub_addr_out !== prev_addr) inv_viol++;
            end
            prev_clk  = hub_clk_out;
            prev_oe_n = hub_oe_n_out;
            prev_addr = hub_addr_out;
            if (toggle) begin
                u_if.row_valid_in = cyc[0];
                u_if.row_in       = ~u_if.row_in;
            end
            @(posedge clk_in);
            #1;
        end
        u_if.row_valid_in = 1'b0;
    endtask

    task automatic check_row(input string tag, input rgb_row_t r, input logic [3:0] exp_addr,
                             input int exp_oe_shift);
        int bad;
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            if (rgb_cap[k] !== pix_of(r, 63 - k)) bad++;
        end
        chk({tag, "_rises"},     64'(nrise), 64'd64);
        chk({tag, "_data"},      64'(bad), 64'd0);
        chk({tag, "_lat_len"},   64'(lat_cnt), 64'd2);
        chk({tag, "_addr"},      64'(addr_lat), 64'(exp_addr));
        chk({tag, "_oe_disp"},   64'(oe_post), 64'd256);
        chk({tag, "_oe_shift"},  64'(oe_shift), 64'(exp_oe_shift));
        chk({tag, "_ready_cyc"}, 64'(ready_cyc + 1), 64'd517);
        chk({tag, "_invariant"}, 64'(inv_viol), 64'd0);
    endtask

    initial begin
        rgb_row_t red_row, bitord_row, pat_row, tmp_row;
        int       rises, n;
        logic     prev;

        red_row = '0;
        red_row.top.red = '1;
        bitord_row = '0;
        bitord_row.top.green[63] = 1'b1;
        bitord_row.bot.blue[0]   = 1'b1;
        pat_row.top.red   = 64'hA5A5_0F0F_1234_5678;
        pat_row.top.green = 64'h0123_4567_89AB_CDEF;
        pat_row.top.blue  = 64'hFFFF_0000_FFFF_0000;
        pat_row.bot.red   = 64'h8000_0000_0000_0001;
        pat_row.bot.green = 64'hDEAD_BEEF_CAFE_F00D;
        pat_row.bot.blue  = 64'h5555_AAAA_3333_CCCC;

        // 1. Reset held with valid asserted
        n_reset_in        = 1'b0;
        u_if.row_valid_in = 1'b1;
        u_if.row_in       = pat_row;
        repeat (3) @(negedge clk_in);
        chk_reset_outputs("reset");
        u_if.row_valid_in = 1'b0;
        n_reset_in        = 1'b1;
        @(posedge clk_in); #1;
        chk("ready_edge1", 64'(u_if.row_ready_out), 64'd0);
        @(posedge clk_in); #1;
        chk("ready_edge2", 64'(u_if.row_ready_out), 64'd1);

        // 2. First row: top red all ones, nothing latched yet so dark during shift
        run_row("red", red_row, 1'b0);
        check_row("red", red_row, 4'd0, 0);
        chk("red_px0",  64'(rgb_cap[0]),  64'h20);
        chk("red_px63", 64'(rgb_cap[63]), 64'h20);

        // 3. Bit order; previous row now displayed during shift
        run_row("bitord", bitord_row, 1'b0);
        check_row("bitord", bitord_row, 4'd1, 256);
        chk("bitord_first", 64'(rgb_cap[0]),  64'h10);
        chk("bitord_last",  64'(rgb_cap[63]), 64'h01);
        chk("bitord_mid",   64'(rgb_cap[31]), 64'h00);

        // 5. Backpressure: valid and row_in toggle while busy
        run_row("bp", pat_row, 1'b1);
        check_row("bp", pat_row, 4'd2, 256);
        repeat (3) @(posedge clk_in);
        #1;
        chk("bp_ready_hold", 64'(u_if.row_ready_out), 64'd1);
        chk("bp_idle_dark",  64'(hub_oe_n_out), 64'd1);

        // 4. Address wrap over 17 rows from a fresh reset
        @(negedge clk_in);
        n_reset_in = 1'b0;
        repeat (2) @(negedge clk_in);
        n_reset_in = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tmp_row = '0;
            tmp_row.top.red   = {$urandom, $urandom};
            tmp_row.bot.green = {$urandom, $urandom};
            run_row("wrap", tmp_row, 1'b0);
            check_row("wrap", tmp_row, 4'(i % 16), (i == 0) ? 0 : 256);
        end

        // 6. Reset in the middle of the shift
        u_if.row_in       = red_row;
        u_if.row_valid_in = 1'b1;
        wait_ready("midrst");
        @(posedge clk_in);
        #1;
        u_if.row_valid_in = 1'b0;
        rises = 0; n = 0; prev = 1'b0;
        while (rises < 20 && n < 300) begin
            @(posedge clk_in);
            #1;
            if (hub_clk_out && !prev) rises++;
            prev = hub_clk_out;
            n++;
        end
        chk("midrst_rises",   64'(rises), 64'd20);
        chk("midrst_pre_rgb", 64'(hub_rgb_out), 64'h20);
        #2;
        n_reset_in = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk_in);
        @(negedge clk_in);
        n_reset_in = 1'b1;
        run_row("after", pat_row, 1'b0);
        check_row("after", pat_row, 4'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
